// File: rtl/memfetch_pkg.sv
// rtl/memfetch_pkg.sv - shared port-interface constants, FSM states and burst sizing for memfetch
package memfetch_pkg;

  localparam int ADDR_W    = 23;
  localparam int DATA_W    = 32;
  localparam int LEN_W     = 2;
  localparam int MAX_BURST = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_DRAIN
  } state_t;

  // Words in the next burst: never more than MAX_BURST, never past the end of the transfer.
  function automatic logic [2:0] burst_words(input logic [15:0] remain);
    return (remain >= 16'(MAX_BURST)) ? 3'(MAX_BURST) : remain[2:0];
  endfunction

endpackage

// File: rtl/memfetch_fifo.sv
// rtl/memfetch_fifo.sv - synchronous first-word-fall-through FIFO with fill count
module memfetch_fifo #(
  parameter int WIDTH = 32,
  parameter int LOG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [LOG:0]     fill
);

  localparam int DEPTH = 1 << LOG;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LOG-1:0]   wr_ptr;
  logic [LOG-1:0]   rd_ptr;
  logic             do_pop;

  // A pop on an empty FIFO is dropped, so a same-cycle push into an empty FIFO is simply stored.
  assign do_pop = pop && !empty;
  assign empty  = (fill == '0);
  assign full   = (fill == (LOG+1)'(DEPTH));
  assign rdata  = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and fill level; push and pop together leave the level unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + LOG'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + LOG'(1);
      end
      case ({push, do_pop})
        2'b10:   fill <= fill + (LOG+1)'(1);
        2'b01:   fill <= fill - (LOG+1)'(1);
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: rtl/memfetch.sv
// rtl/memfetch.sv - streaming burst read client for one DDR controller port
module memfetch
  import memfetch_pkg::*;
#(
  parameter int FIFOLOG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       count,
  output logic              busy,
  output logic [ADDR_W-1:0] memaddr,
  output logic [LEN_W-1:0]  memlen,
  output logic              memwr,
  output logic [DATA_W-1:0] memwdata,
  output logic              memreq,
  input  logic              memack,
  input  logic [DATA_W-1:0] memrdata,
  output logic [DATA_W-1:0] dout,
  output logic              doutvalid,
  input  logic              doutready
);

  localparam int DEPTH = 1 << FIFOLOG;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] nextaddr;
  logic [15:0]       remain;
  logic [15:0]       remain_after;
  logic [2:0]        burst_left;
  logic [2:0]        n;
  logic [FIFOLOG:0]  fill;
  logic [FIFOLOG:0]  free;
  logic [FIFOLOG:0]  need;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              accept;
  logic              issue;
  logic              last_ack;

  // remain only changes on the last ack, so n stays the size of the burst in flight throughout REQ.
  assign n            = burst_words(remain);
  assign remain_after = remain - {13'd0, n};

  // Room is reserved before a request: free slots must cover this burst plus anything still owed.
  assign free = (FIFOLOG+1)'(DEPTH) - fill;
  assign need = (FIFOLOG+1)'(n) + (FIFOLOG+1)'(burst_left);

  assign push     = (state == S_REQ) && memack;
  assign pop      = doutvalid && doutready;
  assign last_ack = push && (burst_left == 3'd1);

  assign memreq    = (state == S_REQ);
  assign busy      = (state != S_IDLE);
  assign memwr     = 1'b0;
  assign memwdata  = '0;
  assign doutvalid = !empty;

  memfetch_fifo #(
    .WIDTH (DATA_W),
    .LOG   (FIFOLOG)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push && !full),
    .wdata (memrdata),
    .pop   (pop),
    .rdata (dout),
    .empty (empty),
    .full  (full),
    .fill  (fill)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; DRAIN exits on the final pop so busy drops the cycle after it.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && (count != 16'd0)) begin
          accept     = 1'b1;
          state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (free >= need) begin
          issue      = 1'b1;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (last_ack) begin
          state_next = (remain_after != 16'd0) ? S_CHECK : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (empty || ((fill == (FIFOLOG+1)'(1)) && pop)) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Transfer counters and the registered burst command, held stable while memreq is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      nextaddr   <= '0;
      remain     <= '0;
      burst_left <= '0;
      memaddr    <= '0;
      memlen     <= '0;
    end else begin
      if (accept) begin
        nextaddr <= addr;
        remain   <= count;
      end
      if (issue) begin
        memaddr    <= nextaddr;
        memlen     <= LEN_W'(n - 3'd1);
        burst_left <= n;
      end
      if (push) begin
        burst_left <= burst_left - 3'd1;
      end
      if (last_ack) begin
        nextaddr <= nextaddr + ADDR_W'(n);
        remain   <= remain_after;
      end
    end
  end

endmodule

// File: tb/tb_memfetch.sv
// tb/tb_memfetch.sv - self-checking bench for memfetch with a latency port model
module tb_memfetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [22:0] addr;
  logic [15:0] count;
  logic        busy;
  logic [22:0] memaddr;
  logic [1:0]  memlen;
  logic        memwr;
  logic [31:0] memwdata;
  logic        memreq;
  logic        memack;
  logic [31:0] memrdata;
  logic [31:0] dout;
  logic        doutvalid;
  logic        doutready;

  localparam int DEPTH = 8;

  always #5 clk = ~clk;

  memfetch #(.FIFOLOG(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .addr      (addr),
    .count     (count),
    .busy      (busy),
    .memaddr   (memaddr),
    .memlen    (memlen),
    .memwr     (memwr),
    .memwdata  (memwdata),
    .memreq    (memreq),
    .memack    (memack),
    .memrdata  (memrdata),
    .dout      (dout),
    .doutvalid (doutvalid),
    .doutready (doutready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer-level model: what must come out, derived from address/count alone.
  logic [31:0] exp_data[$];
  logic [24:0] exp_burst[$];
  int          fill;
  int          words_left;
  bit          exp_busy;
  bit          in_burst;
  bit          prev_memreq;
  int          left;
  logic [22:0] cur_addr;
  logic [1:0]  cur_len;

  logic [22:0] obs_addr[$];
  logic [1:0]  obs_len[$];
  logic [31:0] obs_data[$];

  task automatic model_reset();
    exp_data.delete();
    exp_burst.delete();
    fill       = 0;
    words_left = 0;
    exp_busy   = 1'b0;
    in_burst   = 1'b0;
    left       = 0;
  endtask

  // Compare process: checks the current cycle, then advances the model past the next edge.
  initial begin
    bit          push;
    bit          pop;
    logic [24:0] b;
    int          nb;
    model_reset();
    prev_memreq = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      check("busy", busy, exp_busy);
      check("doutvalid", doutvalid, fill != 0);
      if (memreq === 1'b1 && !in_burst) begin
        if (prev_memreq) check("memreq_gap", prev_memreq, 0);
        obs_addr.push_back(memaddr);
        obs_len.push_back(memlen);
        if (exp_burst.size() == 0) begin
          check("unexpected_burst", memreq, 0);
        end else begin
          b = exp_burst.pop_front();
          check("memaddr", memaddr, b[24:2]);
          check("memlen", memlen, b[1:0]);
        end
        check("reserve", (DEPTH - fill) >= (memlen + 1), 1);
        in_burst = 1'b1;
        left     = memlen + 1;
        cur_addr = memaddr;
        cur_len  = memlen;
      end else if (in_burst) begin
        check("memreq_held", memreq, 1);
        check("memaddr_stable", memaddr, cur_addr);
        check("memlen_stable", memlen, cur_len);
      end
      if (doutvalid === 1'b1 && doutready) begin
        obs_data.push_back(dout);
        if (exp_data.size() == 0) check("unexpected_pop", doutvalid, 0);
        else check("dout", dout, exp_data.pop_front());
      end
      prev_memreq = (memreq === 1'b1);
      if (rst) begin
        model_reset();
      end else begin
        push = memack && (memreq === 1'b1);
        pop  = (doutvalid === 1'b1) && doutready;
        if (push && fill == DEPTH && !pop) check("overflow", fill, DEPTH - 1);
        fill = fill + int'(push) - int'(pop);
        if (push) begin
          left--;
          if (left == 0) in_burst = 1'b0;
        end
        if (pop && words_left > 0) begin
          words_left--;
          if (words_left == 0) exp_busy = 1'b0;
        end
        if (start && !exp_busy && count != 16'd0) begin
          exp_busy   = 1'b1;
          words_left = count;
          for (int o = 0; o < int'(count); o += 4) begin
            nb = (int'(count) - o >= 4) ? 4 : int'(count) - o;
            exp_burst.push_back({23'(addr + 23'(o)), 2'(nb - 1)});
          end
          for (int i = 0; i < int'(count); i++) begin
            exp_data.push_back({9'd0, 23'(addr + 23'(i))});
          end
        end
      end
    end
  end

  // Port model: 5-cycle latency, then one ack per cycle returning the word address.
  logic [22:0] pm_addr;
  logic [1:0]  pm_len;
  initial begin
    memack   = 1'b0;
    memrdata = '0;
    forever begin
      @(negedge clk);
      if (memreq === 1'b1) begin
        pm_addr = memaddr;
        pm_len  = memlen;
        repeat (4) @(negedge clk);
        for (int i = 0; i <= int'(pm_len); i++) begin
          @(negedge clk);
          memack   = 1'b1;
          memrdata = {9'd0, pm_addr + 23'(i)};
        end
        @(negedge clk);
        memack = 1'b0;
      end
    end
  end

  task automatic do_start(input logic [22:0] a, input logic [15:0] c);
    @(negedge clk);
    start = 1'b1;
    addr  = a;
    count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    while (busy === 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ab;
    int db;
    int acks;
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    addr      = '0;
    count     = '0;
    doutready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_memreq", memreq, 0);
    check("rst_memaddr", memaddr, 0);
    check("rst_memlen", memlen, 0);
    check("rst_doutvalid", doutvalid, 0);
    check("memwr", memwr, 0);

    ab = obs_addr.size(); db = obs_data.size();
    do_start(23'h2DBEEF, 16'd4);
    wait_done(200);
    check("single_bursts", obs_addr.size() - ab, 1);
    check("single_addr", obs_addr[ab], 23'h2DBEEF);
    check("single_len", obs_len[ab], 3);
    check("single_words", obs_data.size() - db, 4);
    check("single_first", obs_data[db], 32'h2DBEEF);
    check("single_last", obs_data[db+3], 32'h2DBEF2);

    ab = obs_addr.size(); db = obs_data.size();
    do_start(23'h000100, 16'd10);
    wait_done(300);
    check("multi_bursts", obs_addr.size() - ab, 3);
    check("multi_a0", obs_addr[ab], 23'h100);
    check("multi_a1", obs_addr[ab+1], 23'h104);
    check("multi_a2", obs_addr[ab+2], 23'h108);
    check("multi_l1", obs_len[ab+1], 3);
    check("multi_l2", obs_len[ab+2], 1);
    check("multi_words", obs_data.size() - db, 10);

    ab = obs_addr.size(); db = obs_data.size();
    do_start(23'h7FFFFE, 16'd6);
    wait_done(300);
    check("wrap_bursts", obs_addr.size() - ab, 2);
    check("wrap_a1", obs_addr[ab+1], 23'h000002);
    check("wrap_l1", obs_len[ab+1], 1);
    check("wrap_word2", obs_data[db+2], 32'h0);
    check("wrap_word5", obs_data[db+5], 32'h3);

    ab = obs_addr.size();
    do_start(23'h000123, 16'd0);
    repeat (20) @(negedge clk);
    check("zero_busy", busy, 0);
    check("zero_bursts", obs_addr.size() - ab, 0);

    ab = obs_addr.size(); db = obs_data.size();
    do_start(23'h000200, 16'd8);
    repeat (3) @(negedge clk);
    do_start(23'h000555, 16'd4);
    wait_done(300);
    check("busy_start_bursts", obs_addr.size() - ab, 2);
    check("busy_start_a1", obs_addr[ab+1], 23'h204);
    check("busy_start_words", obs_data.size() - db, 8);

    ab = obs_addr.size(); db = obs_data.size();
    doutready = 1'b0;
    do_start(23'h000300, 16'd16);
    repeat (60) @(negedge clk);
    #2;
    check("bp_bursts", obs_addr.size() - ab, 2);
    check("bp_memreq", memreq, 0);
    check("bp_doutvalid", doutvalid, 1);
    check("bp_busy", busy, 1);
    @(negedge clk);
    doutready = 1'b1;
    wait_done(400);
    check("bp_bursts_total", obs_addr.size() - ab, 4);
    check("bp_words", obs_data.size() - db, 16);
    check("bp_last", obs_data[db+15], 32'h30F);

    do_start(23'h000400, 16'd4);
    acks = 0;
    n = 0;
    while (acks < 2 && n < 100) begin
      @(posedge clk);
      if (memack && memreq) acks++;
      n++;
    end
    check("rstmid_acks", acks, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("rstmid_memreq", memreq, 0);
    check("rstmid_doutvalid", doutvalid, 0);
    check("rstmid_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("rstmid_no_push", doutvalid, 0);

    ab = obs_addr.size(); db = obs_data.size();
    do_start(23'h000500, 16'd5);
    wait_done(300);
    check("after_bursts", obs_addr.size() - ab, 2);
    check("after_a1", obs_addr[ab+1], 23'h504);
    check("after_l1", obs_len[ab+1], 0);
    check("after_words", obs_data.size() - db, 5);
    check("after_last", obs_data[db+4], 32'h504);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
